// File: rtl/vga_glyph_plotter.sv
// Glyph sequencer for the VGA plot wrapper. It reads a 1bpp bitmap one row at a time and emits one pixel per clock.
// Optional build macro PLOT_TRANSPARENT_EN: plot only the set pixels, with colour forced to 1.
module vga_glyph_plotter #(
  parameter int GLYPH_W     = 4,
  parameter int GLYPH_H     = 5,
  parameter int GLYPH_IDX_W = 5,
  parameter int ADDR_W      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [GLYPH_IDX_W-1:0] glyph,
  input  logic [7:0]             pos_in,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  input  logic [GLYPH_W-1:0]     mem_rdata,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic                   colour,
  output logic [7:0]             pos,
  output logic                   plot
);

  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(GLYPH_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(GLYPH_H - 1);
  localparam logic [ADDR_W-1:0] H_A      = ADDR_W'(GLYPH_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLOT,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ROW_W-1:0]       row, row_nxt;
  logic [COL_W-1:0]       col, col_nxt;
  logic [GLYPH_IDX_W-1:0] glyph_q, glyph_nxt;
  logic [GLYPH_W-1:0]     shreg, shreg_nxt;
  logic [ADDR_W-1:0]      addr_nxt;
  logic [7:0]             pos_nxt, x_nxt;
  logic [6:0]             y_nxt;
  logic                   colour_nxt, plot_nxt;
  logic                   emit, pixel, fetch_addr;

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    col_nxt    = col;
    glyph_nxt  = glyph_q;
    pos_nxt    = pos;
    shreg_nxt  = shreg;
    addr_nxt   = mem_addr;
    x_nxt      = x;
    y_nxt      = y;
    colour_nxt = colour;
    plot_nxt   = 1'b0;
    emit       = 1'b0;
    pixel      = 1'b0;
    fetch_addr = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          glyph_nxt  = glyph;
          pos_nxt    = pos_in;
          row_nxt    = '0;
          fetch_addr = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        // Column 0 goes out straight from the read data; the rest are shifted up to the MSB.
        pixel     = mem_rdata[GLYPH_W-1];
        shreg_nxt = mem_rdata << 1;
        col_nxt   = '0;
        emit      = 1'b1;
        state_nxt = S_PLOT;
      end
      S_PLOT: begin
        if (col == COL_LAST) begin
          if (row == ROW_LAST) begin
            state_nxt = S_DONE;
          end else begin
            row_nxt    = row + 1'b1;
            fetch_addr = 1'b1;
            state_nxt  = S_FETCH;
          end
        end else begin
          col_nxt   = col + 1'b1;
          pixel     = shreg[GLYPH_W-1];
          shreg_nxt = shreg << 1;
          emit      = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // The address is formed modulo 2^ADDR_W, so truncating the glyph index first gives the same result.
    if (fetch_addr)
      addr_nxt = ADDR_W'(glyph_nxt) * H_A + ADDR_W'(row_nxt);

    if (emit) begin
`ifdef PLOT_TRANSPARENT_EN
      plot_nxt   = pixel;
      colour_nxt = 1'b1;
`else
      plot_nxt   = 1'b1;
      colour_nxt = pixel;
`endif
      if (plot_nxt) begin
        x_nxt = 8'(col_nxt);
        y_nxt = 7'(row_nxt);
      end else begin
        colour_nxt = colour;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      glyph_q  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= 1'b0;
      pos      <= '0;
      plot     <= 1'b0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      glyph_q  <= glyph_nxt;
      shreg    <= shreg_nxt;
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      mem_rd   <= (state_nxt == S_FETCH);
      mem_addr <= addr_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      colour   <= colour_nxt;
      pos      <= pos_nxt;
      plot     <= plot_nxt;
    end
  end

endmodule

// File: tb/tb_vga_glyph_plotter.sv
// Bench for vga_glyph_plotter. A 4x5 instance with a 6-bit glyph index is checked cycle by cycle against an arithmetic model.
// A second 1x1 instance covers the degenerate glyph size.
module tb_vga_glyph_plotter;
  localparam int GW     = 4;
  localparam int GH     = 5;
  localparam int RC     = GW + 2;
  localparam int DONE_C = 1 + GH * RC;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] glyph = '0;
  logic [7:0] pos_in = '0;
  logic       busy, done, mem_rd, colour, plot;
  logic [7:0] mem_addr, x, pos;
  logic [6:0] y;
  logic [3:0] mem_rdata = '0;
  logic [3:0] mem [256];

  logic       start1 = 1'b0;
  logic [4:0] glyph1 = 5'd2;
  logic [7:0] pos_in1 = 8'h5a;
  logic       busy1, done1, mem_rd1, colour1, plot1;
  logic [7:0] mem_addr1, x1, pos1;
  logic [6:0] y1;
  logic [0:0] mem_rdata1 = '0;
  logic       b1 = 1'b0;

  int tests = 0;
  int fails = 0;
  int plot_seen;

  always #5 clock = ~clock;

  vga_glyph_plotter #(.GLYPH_W(4), .GLYPH_H(5), .GLYPH_IDX_W(6), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .glyph(glyph), .pos_in(pos_in),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .x(x), .y(y), .colour(colour), .pos(pos), .plot(plot));

  vga_glyph_plotter #(.GLYPH_W(1), .GLYPH_H(1), .GLYPH_IDX_W(5), .ADDR_W(8)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .glyph(glyph1), .pos_in(pos_in1),
    .busy(busy1), .done(done1), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_rdata(mem_rdata1),
    .x(x1), .y(y1), .colour(colour1), .pos(pos1), .plot(plot1));

  // Synchronous bitmap memories. Outside a read they return junk so that stray sampling shows up.
  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 4'($urandom);
    mem_rdata1 <= mem_rd1 ? b1 : ~b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge, with start already applied for the coming edge (edge 0). Checks cycles 1..stop_at.
  task automatic check_glyph(input int g, input int p, input bit hold, input int stop_at);
    int k, r, ph, col, a;
    bit on_px, bitv, e_plot;
    plot_seen = 0;
    for (int c = 1; c <= stop_at; c++) begin
      @(negedge clock);
      if (c == 1 && !hold) begin
        start  = 1'b0;
        glyph  = 6'($urandom);
        pos_in = 8'($urandom);
      end
      k  = c - 1;
      r  = (c >= DONE_C) ? GH - 1 : k / RC;
      ph = k % RC;
      a  = (g * GH + r) % 256;
      on_px = (c < DONE_C) && (ph >= 2);
      col   = on_px ? ph - 2 : 0;
      bitv  = on_px ? mem[a][GW-1-col] : 1'b0;
`ifdef PLOT_TRANSPARENT_EN
      e_plot = on_px && bitv;
`else
      e_plot = on_px;
`endif
      chk("busy", 32'(busy), 32'(1));
      chk("done", 32'(done), 32'(c == DONE_C));
      chk("mem_rd", 32'(mem_rd), 32'((c < DONE_C) && (ph == 0)));
      chk("plot", 32'(plot), 32'(e_plot));
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("pos", 32'(pos), 32'(p));
      if (e_plot) begin
        plot_seen++;
        chk("x", 32'(x), 32'(col));
        chk("y", 32'(y), 32'(r));
`ifdef PLOT_TRANSPARENT_EN
        chk("colour", 32'(colour), 32'(1));
`else
        chk("colour", 32'(colour), 32'(bitv));
`endif
      end
    end
  endtask

  task automatic do_glyph(input int g, input int p);
    int exp_cnt;
    start  = 1'b1;
    glyph  = 6'(g);
    pos_in = 8'(p);
    check_glyph(g, p, 1'b0, DONE_C);
    exp_cnt = 0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) begin
`ifdef PLOT_TRANSPARENT_EN
        if (mem[(g * GH + r) % 256][GW-1-c]) exp_cnt++;
`else
        exp_cnt++;
`endif
      end
    chk("plot_count", 32'(plot_seen), 32'(exp_cnt));
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_plot", 32'(plot), 32'(0));
  endtask

  task automatic one_pixel(input bit v);
    b1 = v;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("w1_c1_rd", 32'(mem_rd1), 32'(1));
    chk("w1_c1_addr", 32'(mem_addr1), 32'(2));
    chk("w1_c1_plot", 32'(plot1), 32'(0));
    @(negedge clock);
    chk("w1_c2_rd", 32'(mem_rd1), 32'(0));
    chk("w1_c2_busy", 32'(busy1), 32'(1));
    chk("w1_c2_plot", 32'(plot1), 32'(0));
    @(negedge clock);
`ifdef PLOT_TRANSPARENT_EN
    chk("w1_c3_plot", 32'(plot1), 32'(v));
    if (v) chk("w1_c3_colour", 32'(colour1), 32'(1));
`else
    chk("w1_c3_plot", 32'(plot1), 32'(1));
    chk("w1_c3_colour", 32'(colour1), 32'(v));
`endif
    chk("w1_c3_xy", 32'({x1, 1'b0, y1}), 32'(0));
    chk("w1_c3_done", 32'(done1), 32'(0));
    @(negedge clock);
    chk("w1_c4_done", 32'(done1), 32'(1));
    chk("w1_c4_plot", 32'(plot1), 32'(0));
    chk("w1_c4_pos", 32'(pos1), 32'(8'h5a));
    @(negedge clock);
    chk("w1_c5_busy", 32'(busy1), 32'(0));
    chk("w1_c5_done", 32'(done1), 32'(0));
  endtask

  initial begin
    int g, p;
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);

    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_outs", 32'({done, mem_rd, plot, colour}), 32'(0));
    chk("rst_vals", 32'({x, y, pos, mem_addr}), 32'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy0", 32'(busy), 32'(0));

    mem[15] = 4'b1001; mem[16] = 4'b0110; mem[17] = 4'b1111;
    mem[18] = 4'b0000; mem[19] = 4'b1010;
    do_glyph(3, 7);

    do_glyph(60, 8'($urandom));

    for (int n = 0; n < 4; n++) begin
      g = int'($urandom_range(0, 63));
      p = int'($urandom_range(0, 255));
      do_glyph(g, p);
    end

    // start held high: one glyph per 32 cycles and nothing is accepted in DONE
    g = int'($urandom_range(0, 63));
    p = int'($urandom_range(0, 255));
    start = 1'b1; glyph = 6'(g); pos_in = 8'(p);
    for (int n = 0; n < 3; n++) begin
      check_glyph(g, p, 1'b1, DONE_C);
      if (n == 2) start = 1'b0;
      @(negedge clock);
      chk("held_idle_busy", 32'(busy), 32'(0));
      chk("held_idle_done", 32'(done), 32'(0));
    end
    @(negedge clock);
    chk("held_stop_busy", 32'(busy), 32'(0));

    // reset in the middle of PLOT (row 2, col 1)
    g = int'($urandom_range(0, 63));
    start = 1'b1; glyph = 6'(g); pos_in = 8'h33;
    check_glyph(g, 8'h33, 1'b0, 16);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_plot", 32'(plot), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_regs", 32'({x, y, pos, mem_addr}), 32'(0));
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("in_rst_done", 32'(done), 32'(0));
      chk("in_rst_busy", 32'(busy), 32'(0));
    end
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_done", 32'(done), 32'(0));
    do_glyph(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));

    one_pixel(1'b1);
    one_pixel(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
